// File: rtl/h264_pkg.sv
// Shared constants and packer state encoding for the H.264 NAL byte packer.
package h264_pkg;
   localparam logic [7:0] EPB_BYTE  = 8'h03;
   localparam logic       RBSP_STOP = 1'b1;

   typedef enum logic [1:0] {PK_IDLE, PK_DRAIN, PK_FLUSH} packer_state_t;
endpackage

// File: rtl/h264_byte_fifo.sv
// Byte FIFO with extra-bit pointers; reads of an empty FIFO return zero.
module h264_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_wr, do_rd;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; emptiness is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/h264_nal_packer.sv
// Packs right-aligned VLC codes MSB-first into bytes, inserts emulation
// prevention bytes, appends the RBSP trailing bits on flush.
module h264_nal_packer
   import h264_pkg::*;
#(
   parameter int CODE_W     = 128,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 16,
   parameter bit EPB_EN     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] code_bits,
   input  logic [LEN_W-1:0]  code_len,
   input  logic              flush,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic              flush_done,
   output logic [31:0]       out_byte_cnt
);
   localparam int                ACC_W    = CODE_W + 8;
   localparam int                FILL_W   = $clog2(ACC_W + 1);
   localparam logic [31:0]       ACC_W_U  = ACC_W;
   localparam logic [31:0]       CODE_MAX = CODE_W;
   localparam logic [FILL_W-1:0] EIGHT    = FILL_W'(8);
   localparam logic [ACC_W-1:0]  STOP_ACC = {{(ACC_W-1){1'b0}}, RBSP_STOP};

   packer_state_t     state, state_nxt;
   logic [ACC_W-1:0]  acc, acc_nxt;
   logic [FILL_W-1:0] fill, fill_nxt;
   logic [1:0]        zero_cnt, zero_cnt_nxt;
   logic [31:0]       byte_cnt, len, total;
   logic [7:0]        cand, fifo_wdata;
   logic              accept, ins, fifo_wr, fifo_full, fifo_empty;

   function automatic logic [31:0] sat_len(input logic [LEN_W-1:0] l);
      if (32'(l) > CODE_MAX) return CODE_MAX;
      return 32'(l);
   endfunction

   // Masks the code to its length and lands it just below the valid bits.
   function automatic logic [ACC_W-1:0] place_code(input logic [CODE_W-1:0] bits,
                                                   input logic [31:0] l,
                                                   input logic [31:0] fill_v);
      logic [ACC_W-1:0] mask;
      mask = ~({ACC_W{1'b1}} << l);
      return ({8'h00, bits} & mask) << (ACC_W_U - fill_v - l);
   endfunction

   assign in_ready     = (fill < EIGHT) && (state != PK_FLUSH);
   assign accept       = in_ready & (code_valid | flush);
   assign cand         = acc[ACC_W-1 -: 8];
   assign flush_done   = (state == PK_FLUSH) && (fill == '0);
   assign out_valid    = ~fifo_empty;
   assign out_byte_cnt = byte_cnt;

   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      fill_nxt     = fill;
      zero_cnt_nxt = zero_cnt;
      fifo_wr      = 1'b0;
      fifo_wdata   = cand;
      ins          = 1'b0;
      len          = '0;
      total        = 32'(fill);
      if (accept) begin
         if (code_valid) begin
            len     = sat_len(code_len);
            acc_nxt = acc | place_code(code_bits, len, total);
            total   = total + len;
         end
         // Stop bit goes right after the code; bits below are already zero.
         if (flush) begin
            acc_nxt   = acc_nxt | (STOP_ACC << (ACC_W_U - 32'd1 - total));
            total     = (total + 32'd8) & ~32'd7;
            state_nxt = PK_FLUSH;
         end
         fill_nxt = FILL_W'(total);
      end else if (flush_done) begin
         zero_cnt_nxt = 2'd0;
         state_nxt    = PK_IDLE;
      end else if ((fill >= EIGHT) && !fifo_full) begin
         ins     = EPB_EN && (zero_cnt == 2'd2) && (cand <= EPB_BYTE);
         fifo_wr = 1'b1;
         if (ins) begin
            fifo_wdata   = EPB_BYTE;
            zero_cnt_nxt = 2'd0;
         end else begin
            acc_nxt      = acc << 8;
            fill_nxt     = fill - EIGHT;
            zero_cnt_nxt = (cand != 8'h00) ? 2'd0 :
                           (zero_cnt == 2'd2) ? 2'd2 : zero_cnt + 2'd1;
         end
      end
      if (state_nxt != PK_FLUSH)
         state_nxt = (fill_nxt >= EIGHT) ? PK_DRAIN : PK_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= PK_IDLE;
         acc      <= '0;
         fill     <= '0;
         zero_cnt <= '0;
         byte_cnt <= '0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         fill     <= fill_nxt;
         zero_cnt <= zero_cnt_nxt;
         if (out_valid && out_ready) byte_cnt <= byte_cnt + 32'd1;
      end
   end

   h264_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .full    (fifo_full),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .empty   (fifo_empty)
   );
endmodule

// File: tb/tb_h264_nal_packer.sv
// Directed bench for h264_nal_packer: one instance with emulation prevention, one without.
module tb_h264_nal_packer;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         code_valid, flush, in_ready, out_valid, out_ready, flush_done;
   logic [127:0] code_bits;
   logic [7:0]   code_len, out_data;
   logic [31:0]  out_byte_cnt;
   logic         b_code_valid, b_flush, b_in_ready, b_out_valid, b_out_ready, b_flush_done;
   logic [127:0] b_code_bits;
   logic [7:0]   b_code_len, b_out_data;
   logic [31:0]  b_out_byte_cnt;

   int          n_chk = 0;
   int          n_err = 0;
   int          fd_cnt = 0;
   int          exp_cnt = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  b_got_q[$];
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   h264_nal_packer #(.CODE_W(128), .LEN_W(8), .FIFO_DEPTH(16), .EPB_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .code_valid(code_valid), .code_bits(code_bits),
      .code_len(code_len), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .flush_done(flush_done),
      .out_byte_cnt(out_byte_cnt));

   h264_nal_packer #(.CODE_W(128), .LEN_W(8), .FIFO_DEPTH(16), .EPB_EN(1'b0)) dut_raw (
      .clk(clk), .rst(rst), .code_valid(b_code_valid), .code_bits(b_code_bits),
      .code_len(b_code_len), .flush(b_flush), .in_ready(b_in_ready), .out_valid(b_out_valid),
      .out_data(b_out_data), .out_ready(b_out_ready), .flush_done(b_flush_done),
      .out_byte_cnt(b_out_byte_cnt));

   // Records handshakes half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back(out_data);
      if (!rst && b_out_valid && b_out_ready) b_got_q.push_back(b_out_data);
      if (!rst && flush_done) fd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input bit sel, input logic [127:0] bits, input logic [7:0] len,
                       input bit v, input bit fl);
      int t;
      t = 0;
      if (sel) begin
         b_code_valid = v; b_code_bits = bits; b_code_len = len; b_flush = fl;
      end else begin
         code_valid = v; code_bits = bits; code_len = len; flush = fl;
      end
      while (!(sel ? b_in_ready : in_ready) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("send_accept", 32'(t < 100), 32'd1);
      @(posedge clk);
      #1;
      code_valid = 1'b0; flush = 1'b0; b_code_valid = 1'b0; b_flush = 1'b0;
   endtask

   task automatic check_stream(input string tag, input bit sel);
      logic [7:0] g[$];
      if (sel) g = b_got_q;
      else g = got_q;
      chk({tag, "_len"}, 32'(g.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < g.size()) chk(tag, 32'(g[i]), 32'(exp_q[i]));
      if (!sel) exp_cnt += exp_q.size();
      if (sel) b_got_q.delete();
      else got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fd0;
      code_valid = 0; flush = 0; code_bits = '0; code_len = '0; out_ready = 1'b1;
      b_code_valid = 0; b_flush = 0; b_code_bits = '0; b_code_len = '0; b_out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_cnt", out_byte_cnt, 32'd0);
      idle(2);
      rst = 1'b0;
      idle(1);

      send(0, 128'hA5, 8'd8, 1'b1, 1'b0);
      chk("lat_early", 32'(out_valid), 32'd0);
      idle(1);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'hA5);
      idle(3);
      exp_q = '{8'hA5};
      check_stream("byte_a5", 0);
      chk("cnt_a5", out_byte_cnt, 32'(exp_cnt));

      send(0, 128'h000001, 8'd24, 1'b1, 1'b0);
      idle(8);
      exp_q = '{8'h00, 8'h00, 8'h03, 8'h01};
      check_stream("epb_001", 0);
      chk("cnt_001", out_byte_cnt, 32'(exp_cnt));

      fd0 = fd_cnt;
      send(0, 128'h5, 8'd3, 1'b1, 1'b0);
      send(0, 128'h0, 8'd0, 1'b0, 1'b1);
      idle(6);
      exp_q = '{8'hB0};
      check_stream("flush_b0", 0);
      chk("flush_b0_done", 32'(fd_cnt - fd0), 32'd1);
      chk("flush_b0_ready", 32'(in_ready), 32'd1);

      fd0 = fd_cnt;
      send(0, 128'h3, 8'd2, 1'b1, 1'b1);
      idle(6);
      exp_q = '{8'hE0};
      check_stream("flush_e0", 0);
      chk("flush_e0_done", 32'(fd_cnt - fd0), 32'd1);

      send(0, 128'hFF, 8'd0, 1'b1, 1'b0);
      idle(4);
      check_stream("len0", 0);
      chk("len0_valid", 32'(out_valid), 32'd0);

      send(0, {16{8'hC3}}, 8'hFF, 1'b1, 1'b0);
      idle(25);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'hC3);
      check_stream("len_sat", 0);

      send(0, 128'h0, 8'd32, 1'b1, 1'b0);
      idle(10);
      exp_q = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
      check_stream("epb_zero", 0);
      chk("cnt_zero", out_byte_cnt, 32'(exp_cnt));

      send(1, 128'h0, 8'd32, 1'b1, 1'b0);
      idle(8);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      check_stream("raw_zero", 1);
      chk("raw_cnt", b_out_byte_cnt, 32'd4);

      out_ready = 1'b0;
      send(0, {128{1'b1}}, 8'd128, 1'b1, 1'b0);
      idle(20);
      chk("full_valid", 32'(out_valid), 32'd1);
      send(0, 128'hA5, 8'd8, 1'b1, 1'b0);
      idle(5);
      chk("full_stall_ready", 32'(in_ready), 32'd0);
      chk("full_no_out", 32'(got_q.size()), 32'd0);
      out_ready = 1'b1;
      idle(30);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'hFF);
      exp_q.push_back(8'hA5);
      check_stream("full_drain", 0);
      chk("full_ready_after", 32'(in_ready), 32'd1);
      chk("cnt_full", out_byte_cnt, 32'(exp_cnt));

      out_ready = 1'b0;
      send(0, {16{8'h5A}}, 8'd128, 1'b1, 1'b0);
      idle(3);
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_cnt", out_byte_cnt, 32'd0);
      idle(1);
      rst = 1'b0;
      out_ready = 1'b1;
      idle(1);
      got_q.delete();
      exp_cnt = 0;
      send(0, 128'hA5, 8'd8, 1'b1, 1'b0);
      idle(5);
      exp_q = '{8'hA5};
      check_stream("post_rst", 0);
      chk("cnt_post_rst", out_byte_cnt, 32'(exp_cnt));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
